// File: rtl/entropy_collector.sv
// entropy_collector
// Requester for the es_ entropy interface. Polls the entropy source with
// single-cycle es_entropy_req strobes, backs off after WAIT/BIST, gives up
// on DEAD or after RETRY_LIMIT consecutive non-ES16 polls, and packs SAMPLES
// 16-bit samples into one W-bit response word.
//
// Ports
//   g_clk, g_resetn      clock, asynchronous active-low reset
//   rq_valid/rq_ready    request for one W-bit word (accepted only in IDLE)
//   rs_valid/rs_ready    response handshake; rs_data/rs_error held until taken
//   rs_data [W-1:0]      random word, zero on error
//   rs_error             DEAD source or retry limit reached
//   es_entropy_req       poll strobe, high only in POLL
//   es_entropy_opst[1:0] 00 BIST, 01 ES16, 10 WAIT, 11 DEAD (sampled with req)
//   es_entropy_data[15:0] sample, valid with req when opst == ES16
//
// state   | meaning
// IDLE    | waiting for a request, rq_ready high
// POLL    | es_entropy_req high, status decoded this cycle
// BACKOFF | req low for WAIT_CYCLES cycles after WAIT/BIST
// DONE    | word delivered, waiting for rs_ready
// FAIL    | error response, waiting for rs_ready
module entropy_collector #(
  parameter int SAMPLES     = 2,
  parameter int WAIT_CYCLES = 4,
  parameter int RETRY_LIMIT = 64,
  localparam int W          = 16 * SAMPLES
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         rq_valid,
  output logic         rq_ready,
  output logic         rs_valid,
  input  logic         rs_ready,
  output logic [W-1:0] rs_data,
  output logic         rs_error,
  output logic         es_entropy_req,
  input  logic [1:0]   es_entropy_opst,
  input  logic [15:0]  es_entropy_data
);

  localparam logic [1:0] OPST_ES16 = 2'b01;
  localparam logic [1:0] OPST_DEAD = 2'b11;
  localparam logic [1:0] CNT_LAST  = 2'(SAMPLES - 1);
  localparam logic [7:0] RTY_LIM   = 8'(RETRY_LIMIT);
  localparam logic [7:0] BO_LOAD   = 8'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_POLL,
    S_BACKOFF,
    S_DONE,
    S_FAIL
  } state_e;

  state_e       state_q, state_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [7:0]   rty_q, rty_d;
  logic [7:0]   bo_q, bo_d;
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] data_q, data_d;
  logic [W-1:0] acc_shift;

  // New sample enters at the top so the first sample ends up in [15:0].
  generate
    if (SAMPLES == 1) begin : g_single
      assign acc_shift = es_entropy_data;
    end else begin : g_multi
      assign acc_shift = {es_entropy_data, acc_q[W-1:16]};
    end
  endgenerate

  always_ff @(posedge g_clk or negedge g_resetn) begin
    if (!g_resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rty_q   <= '0;
      bo_q    <= '0;
      acc_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rty_q   <= rty_d;
      bo_q    <= bo_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rty_d   = rty_q;
    bo_d    = bo_q;
    acc_d   = acc_q;
    data_d  = data_q;
    case (state_q)
      S_IDLE: begin
        if (rq_valid) begin
          cnt_d   = '0;
          rty_d   = '0;
          acc_d   = '0;
          state_d = S_POLL;
        end
      end
      S_POLL: begin
        if (es_entropy_opst == OPST_ES16) begin
          acc_d = acc_shift;
          rty_d = '0;
          if (cnt_q == CNT_LAST) begin
            data_d  = acc_shift;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end else if (es_entropy_opst == OPST_DEAD) begin
          acc_d   = '0;
          state_d = S_FAIL;
        end else begin
          rty_d = rty_q + 8'd1;
          if (rty_d == RTY_LIM) begin
            acc_d   = '0;
            state_d = S_FAIL;
          end else begin
            bo_d    = BO_LOAD;
            state_d = S_BACKOFF;
          end
        end
      end
      S_BACKOFF: begin
        if (bo_q == 8'd0) state_d = S_POLL;
        else              bo_d    = bo_q - 8'd1;
      end
      S_DONE: begin
        if (rs_ready) state_d = S_IDLE;
      end
      S_FAIL: begin
        if (rs_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rq_ready       = (state_q == S_IDLE);
  assign es_entropy_req = (state_q == S_POLL);
  assign rs_valid       = (state_q == S_DONE) || (state_q == S_FAIL);
  assign rs_error       = (state_q == S_FAIL);
  assign rs_data        = (state_q == S_DONE) ? data_q : '0;

endmodule

// File: tb/tb_entropy_collector.sv
module tb_entropy_collector;

  localparam int SAMPLES     = 2;
  localparam int WAIT_CYCLES = 4;
  localparam int RETRY_LIMIT = 3;
  localparam int W           = 16 * SAMPLES;

  localparam logic [1:0] BIST = 2'b00;
  localparam logic [1:0] ES16 = 2'b01;
  localparam logic [1:0] WAIT = 2'b10;
  localparam logic [1:0] DEAD = 2'b11;

  typedef struct packed {
    logic [1:0]  op;
    logic [15:0] d;
  } resp_t;

  logic         g_clk = 1'b0;
  logic         g_resetn = 1'b0;
  logic         rq_valid = 1'b0;
  logic         rq_ready;
  logic         rs_valid;
  logic         rs_ready = 1'b0;
  logic [W-1:0] rs_data;
  logic         rs_error;
  logic         es_entropy_req;
  logic [1:0]   es_entropy_opst = 2'b00;
  logic [15:0]  es_entropy_data = 16'h0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  resp_t src[$];
  int    polls[$];

  entropy_collector #(
    .SAMPLES    (SAMPLES),
    .WAIT_CYCLES(WAIT_CYCLES),
    .RETRY_LIMIT(RETRY_LIMIT)
  ) dut (
    .g_clk          (g_clk),
    .g_resetn       (g_resetn),
    .rq_valid       (rq_valid),
    .rq_ready       (rq_ready),
    .rs_valid       (rs_valid),
    .rs_ready       (rs_ready),
    .rs_data        (rs_data),
    .rs_error       (rs_error),
    .es_entropy_req (es_entropy_req),
    .es_entropy_opst(es_entropy_opst),
    .es_entropy_data(es_entropy_data)
  );

  always #5 g_clk = ~g_clk;

  always @(posedge g_clk) cyc = cyc + 1;

  // Entropy source: one response per req-high cycle, junk otherwise.
  always @(negedge g_clk) begin
    resp_t r;
    if (g_resetn && es_entropy_req) begin
      polls.push_back(cyc);
      if (src.size() > 0) begin
        r = src.pop_front();
        es_entropy_opst = r.op;
        es_entropy_data = r.d;
      end else begin
        es_entropy_opst = BIST;
        es_entropy_data = 16'($urandom);
      end
    end else begin
      es_entropy_opst = 2'($urandom);
      es_entropy_data = 16'($urandom);
    end
  end

  task automatic run_txn(input string name, input resp_t seq[$], input int hold);
    int           t0, tv, off, n, rty, k;
    logic         exp_err;
    logic [W-1:0] exp_data;
    int           exp_polls[$];
    int           exp_tv;
    // Reference: walk the response list applying the polling rules.
    off = 1; n = 0; rty = 0; exp_err = 1'b0; exp_data = '0;
    foreach (seq[i]) begin
      exp_polls.push_back(off);
      if (seq[i].op == ES16) begin
        exp_data = exp_data | (W'(seq[i].d) << (16 * n));
        n++; rty = 0;
        if (n == SAMPLES) break;
        off += 1;
      end else if (seq[i].op == DEAD) begin
        exp_err = 1'b1; break;
      end else begin
        rty++;
        if (rty == RETRY_LIMIT) begin exp_err = 1'b1; break; end
        off += 1 + WAIT_CYCLES;
      end
    end
    if (exp_err) exp_data = '0;
    exp_tv = off + 1;

    src.delete();
    foreach (seq[i]) src.push_back(seq[i]);
    polls.delete();
    @(negedge g_clk);
    rq_valid = 1'b1;
    t0 = cyc;
    @(negedge g_clk);
    rq_valid = 1'b0;
    k = 0;
    while (!rs_valid && k < 400) begin
      @(negedge g_clk);
      k++;
    end
    tv = cyc;
    checks++;
    if (!rs_valid) begin
      errors++;
      $display("FAIL %s rs_valid timeout: got 0 want 1", name);
    end
    checks++;
    if (tv - t0 !== exp_tv) begin
      errors++;
      $display("FAIL %s rs_valid latency: got %0d want %0d", name, tv - t0, exp_tv);
    end
    checks++;
    if (polls.size() !== exp_polls.size()) begin
      errors++;
      $display("FAIL %s poll count: got %0d want %0d", name, polls.size(), exp_polls.size());
    end else begin
      foreach (exp_polls[i]) begin
        checks++;
        if (polls[i] - t0 !== exp_polls[i]) begin
          errors++;
          $display("FAIL %s poll %0d offset: got %0d want %0d", name, i, polls[i] - t0, exp_polls[i]);
        end
      end
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (rs_valid !== 1'b1 || rs_data !== exp_data || rs_error !== exp_err ||
          rq_ready !== 1'b0 || es_entropy_req !== 1'b0) begin
        errors++;
        $display("FAIL %s response hold %0d: got v=%b d=%h e=%b rq=%b req=%b want v=1 d=%h e=%b rq=0 req=0",
                 name, h, rs_valid, rs_data, rs_error, rq_ready, es_entropy_req, exp_data, exp_err);
      end
      if (h < hold) @(negedge g_clk);
    end
    rs_ready = 1'b1;
    @(negedge g_clk);
    rs_ready = 1'b0;
    checks++;
    if (rs_valid !== 1'b0 || rq_ready !== 1'b1 || es_entropy_req !== 1'b0) begin
      errors++;
      $display("FAIL %s return to idle: got v=%b rq=%b req=%b want v=0 rq=1 req=0",
               name, rs_valid, rq_ready, es_entropy_req);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (rq_ready !== 1'b1 || rs_valid !== 1'b0 || rs_error !== 1'b0 ||
        rs_data !== '0 || es_entropy_req !== 1'b0) begin
      errors++;
      $display("FAIL reset state: got rq=%b v=%b e=%b d=%h req=%b want rq=1 v=0 e=0 d=0 req=0",
               rq_ready, rs_valid, rs_error, rs_data, es_entropy_req);
    end
  endtask

  task automatic test_directed();
    resp_t s[$];
    s = '{'{ES16, 16'h1234}, '{ES16, 16'hABCD}};
    run_txn("basic", s, 0);
    s = '{'{WAIT, 16'h0}, '{ES16, 16'h5555}, '{ES16, 16'h0F0F}};
    run_txn("wait_backoff", s, 0);
    s = '{'{ES16, 16'h1111}, '{DEAD, 16'h9999}};
    run_txn("dead", s, 0);
    s = '{'{ES16, 16'h2222}, '{ES16, 16'h3333}};
    run_txn("after_dead", s, 0);
    s = '{'{BIST, 16'h0}, '{BIST, 16'h0}, '{BIST, 16'h0}, '{BIST, 16'h0}, '{BIST, 16'h0}};
    run_txn("retry_limit", s, 3);
    s = '{'{WAIT, 16'h0}, '{BIST, 16'h0}, '{ES16, 16'hC001}, '{WAIT, 16'h0},
          '{WAIT, 16'h0}, '{ES16, 16'hBEEF}};
    run_txn("retry_reset", s, 0);
    s = '{'{ES16, 16'h7E57}, '{ES16, 16'h00FF}};
    run_txn("hold_ready_low", s, 10);
  endtask

  task automatic test_random();
    resp_t s[$];
    resp_t r;
    int    p;
    for (int t = 0; t < 40; t++) begin
      s.delete();
      for (int i = 0; i < 12; i++) begin
        p = $urandom_range(0, 19);
        if (p < 13)      r.op = ES16;
        else if (p < 16) r.op = WAIT;
        else if (p < 19) r.op = BIST;
        else             r.op = DEAD;
        r.d = 16'($urandom);
        s.push_back(r);
      end
      r.op = ES16; r.d = 16'($urandom); s.push_back(r);
      r.op = ES16; r.d = 16'($urandom); s.push_back(r);
      run_txn("random", s, $urandom_range(0, 4));
    end
  endtask

  task automatic test_reset_in_backoff();
    resp_t s[$];
    src.delete();
    src.push_back('{WAIT, 16'h0});
    polls.delete();
    @(negedge g_clk);
    rq_valid = 1'b1;
    @(negedge g_clk);
    rq_valid = 1'b0;
    @(negedge g_clk);
    @(negedge g_clk);
    #2 g_resetn = 1'b0;
    #1;
    checks++;
    if (rq_ready !== 1'b1 || rs_valid !== 1'b0 || rs_error !== 1'b0 ||
        rs_data !== '0 || es_entropy_req !== 1'b0) begin
      errors++;
      $display("FAIL async reset: got rq=%b v=%b e=%b d=%h req=%b want rq=1 v=0 e=0 d=0 req=0",
               rq_ready, rs_valid, rs_error, rs_data, es_entropy_req);
    end
    @(negedge g_clk);
    g_resetn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge g_clk);
      checks++;
      if (es_entropy_req !== 1'b0 || rq_ready !== 1'b1) begin
        errors++;
        $display("FAIL post-reset idle cycle %0d: got req=%b rq=%b want req=0 rq=1",
                 i, es_entropy_req, rq_ready);
      end
    end
    s = '{'{ES16, 16'hA5A5}, '{ES16, 16'h5A5A}};
    run_txn("after_reset", s, 1);
  endtask

  initial begin
    g_resetn = 1'b0;
    #22;
    test_reset();
    @(negedge g_clk);
    g_resetn = 1'b1;
    test_directed();
    test_reset_in_backoff();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
